// File: rtl/alu_writeback.sv
// In-order ALU writeback stage: skid FIFO into the register-file write port,
// architectural flag register, retire counter. Forwarding built when ALU_WB_FWD_EN is defined.
module alu_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          alu_out,
  input  logic [ADDR_W-1:0]          addr_out,
  input  logic                       wr_en,
  input  logic                       flag_en,
  input  logic                       za,
  input  logic                       zb,
  input  logic                       eq,
  input  logic                       gt,
  input  logic                       lt,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  input  logic                       rf_ready,
  output logic [4:0]                 flags_q,
  output logic [15:0]                retire_cnt,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       fwd_valid,
  output logic [ADDR_W-1:0]          fwd_addr,
  output logic [DATA_W-1:0]          fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic              wr_mem   [DEPTH];
  logic              fe_mem   [DEPTH];
  logic [4:0]        flg_mem  [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_next;
  logic              push;
  logic              head_valid;
  logic              head_wr;
  logic              retire;

  assign push       = in_valid && in_ready;
  assign head_valid = (count != '0);
  assign head_wr    = wr_mem[rd_ptr];
  assign retire     = head_valid && (!head_wr || rf_ready);

  always_comb begin
    count_next = count;
    if (push && !retire)
      count_next = count + 1'b1;
    else if (!push && retire)
      count_next = count - 1'b1;
  end

  // Control state: pointers, occupancy, registered ready, flags, retire count
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      in_ready   <= 1'b1;
      flags_q    <= '0;
      retire_cnt <= '0;
    end else begin
      count    <= count_next;
      // Ready is registered from next occupancy, so a retire in FULL raises it one cycle later
      in_ready <= (count_next < CNT_W'(DEPTH));
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (retire) begin
        rd_ptr     <= rd_ptr + 1'b1;
        retire_cnt <= retire_cnt + 16'd1;
        if (fe_mem[rd_ptr])
          flags_q <= flg_mem[rd_ptr];
      end
    end
  end

  // Entry storage: data path is not reset; validity comes from count
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= alu_out;
      addr_mem[wr_ptr] <= addr_out;
      wr_mem[wr_ptr]   <= wr_en;
      fe_mem[wr_ptr]   <= flag_en;
      flg_mem[wr_ptr]  <= {za, zb, eq, gt, lt};
    end
  end

  assign rf_we    = head_valid && head_wr;
  assign rf_waddr = head_valid ? addr_mem[rd_ptr] : '0;
  assign rf_wdata = head_valid ? data_mem[rd_ptr] : '0;

`ifdef ALU_WB_FWD_EN
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match is the youngest writing entry
  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && wr_mem[idx]) begin
        fwd_valid = 1'b1;
        fwd_addr  = addr_mem[idx];
        fwd_data  = data_mem[idx];
      end
    end
  end
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: expected register writes are queued at accept
// and popped when the DUT performs a write; directed checks cover flags, counts, ready, forwarding.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_out;
  logic [2:0]  addr_out;
  logic        wr_en;
  logic        flag_en;
  logic [4:0]  in_flags;
  logic        za, zb, eq, gt, lt;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_ready;
  logic [4:0]  flags_q;
  logic [15:0] retire_cnt;
  logic [1:0]  count;
  logic        fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;

  int total = 0;
  int bad   = 0;
  logic [18:0] sb_q[$];

  assign {za, zb, eq, gt, lt} = in_flags;

  alu_writeback #(.DATA_W(16), .ADDR_W(3), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .addr_out(addr_out), .wr_en(wr_en), .flag_en(flag_en),
    .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .flags_q(flags_q), .retire_cnt(retire_cnt), .count(count),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] d, input logic [2:0] a, input logic w,
                        input logic f, input logic [4:0] fl);
    in_valid = 1'b1;
    alu_out  = d;
    addr_out = a;
    wr_en    = w;
    flag_en  = f;
    in_flags = fl;
    if (in_ready && w)
      sb_q.push_back({a, d});
  endtask

  // A write happens at the next edge whenever rf_we && rf_ready is seen here
  always @(negedge clk) begin
    if (!rst && rf_we && rf_ready) begin
      if (sb_q.size() == 0)
        chk("wr_unexpected", 32'd1, 32'd0);
      else
        chk("wr_order", {13'd0, rf_waddr, rf_wdata}, {13'd0, sb_q.pop_front()});
    end
  end

  logic fwd_on;

  initial begin
`ifdef ALU_WB_FWD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0; alu_out = '0; addr_out = '0; wr_en = 1'b0;
    flag_en = 1'b0; in_flags = '0; rf_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_fwd", fwd_valid, 0);

    // single write
    rf_ready = 1'b1;
    set_in(16'h1234, 3'd3, 1'b1, 1'b0, 5'b0);
    tick();
    in_valid = 1'b0;
    chk("single_we", rf_we, 1);
    chk("single_addr", rf_waddr, 3);
    chk("single_data", rf_wdata, 16'h1234);
    tick();
    chk("single_retire", retire_cnt, 1);
    chk("single_count", count, 0);

    // compare-only retires without rf_ready
    rf_ready = 1'b0;
    set_in(16'h5555, 3'd1, 1'b0, 1'b1, 5'b00100);
    tick();
    in_valid = 1'b0;
    chk("cmp_count", count, 1);
    chk("cmp_we", rf_we, 0);
    tick();
    chk("cmp_drained", count, 0);
    chk("cmp_flags", flags_q, 5'b00100);
    chk("cmp_retire", retire_cnt, 2);

    // backpressure and full
    set_in(16'hAAAA, 3'd1, 1'b1, 1'b1, 5'b00010);
    tick();
    set_in(16'hBBBB, 3'd2, 1'b1, 1'b0, 5'b11111);
    tick();
    chk("bp_count", count, 2);
    chk("bp_ready", in_ready, 0);
    chk("bp_head", rf_wdata, 16'hAAAA);
    chk("bp_fwd_v", fwd_valid, fwd_on);
    chk("bp_fwd_d", fwd_data, fwd_on ? 16'hBBBB : 16'h0);
    set_in(16'hCCCC, 3'd3, 1'b1, 1'b0, 5'b0);
    tick();
    in_valid = 1'b0;
    chk("bp_ignored", count, 2);
    chk("bp_hold_we", rf_we, 1);
    chk("bp_hold_addr", rf_waddr, 1);
    chk("bp_hold_data", rf_wdata, 16'hAAAA);
    rf_ready = 1'b1;
    tick();
    chk("bp_ready_back", in_ready, 1);
    chk("bp_count1", count, 1);
    chk("bp_next", rf_wdata, 16'hBBBB);
    chk("bp_flags", flags_q, 5'b00010);
    chk("bp_retire", retire_cnt, 3);
    tick();
    chk("bp_flags_hold", flags_q, 5'b00010);
    chk("bp_retire2", retire_cnt, 4);

    // back-to-back stream
    for (int i = 0; i < 4; i++) begin
      set_in(16'h0100 + 16'(i), 3'(i + 4), 1'b1, 1'b0, 5'b0);
      tick();
      chk("strm_count", count, 1);
      chk("strm_we", rf_we, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("strm_empty", count, 0);
    chk("strm_retire", retire_cnt, 8);

    // forwarding picks youngest pending write
    rf_ready = 1'b0;
    set_in(16'h0011, 3'd2, 1'b1, 1'b0, 5'b0);
    tick();
    set_in(16'h0022, 3'd5, 1'b1, 1'b0, 5'b0);
    tick();
    in_valid = 1'b0;
    chk("fwd_valid", fwd_valid, fwd_on);
    chk("fwd_addr", fwd_addr, fwd_on ? 3'd5 : 3'd0);
    chk("fwd_data", fwd_data, fwd_on ? 16'h0022 : 16'h0);
    rf_ready = 1'b1;
    tick();
    chk("fwd_after1", fwd_data, fwd_on ? 16'h0022 : 16'h0);
    tick();
    chk("fwd_empty", fwd_valid, 0);

    // reset mid-drain discards pending entries
    rf_ready = 1'b0;
    set_in(16'hDEAD, 3'd6, 1'b1, 1'b1, 5'b00001);
    tick();
    set_in(16'hBEEF, 3'd7, 1'b1, 1'b1, 5'b00001);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    tick();
    rst = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_we", rf_we, 0);
    chk("mrst_flags", flags_q, 0);
    chk("mrst_retire", retire_cnt, 0);
    chk("mrst_ready", in_ready, 1);
    rf_ready = 1'b1;
    repeat (3) tick();
    chk("mrst_no_write", rf_we, 0);

    // retire counter wrap using compare-only entries
    set_in(16'h0, 3'd0, 1'b0, 1'b0, 5'b0);
    repeat (65535) tick();
    in_valid = 1'b0;
    tick();
    chk("wrap_max", retire_cnt, 16'hFFFF);
    set_in(16'h0, 3'd0, 1'b0, 1'b0, 5'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("wrap_zero", retire_cnt, 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
